nf_dm_ctrl: RTL and testbench

- Data-memory controller directly downstream of the instruction load/store unit.
- Accepts one LSU request per transaction on the `req_dm`/`req_ack_dm` handshake and decodes it to either the local synchronous data RAM or the peripheral bus.
- Generates byte-lane strobes and replicated write data, and returns right-aligned, zero-extended load data.
- Flags misaligned accesses and peripheral timeouts. Sign extension is done in the writeback stage.

---
 rtl/nf_dm_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_nf_dm_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_dm_ctrl.sv
// Data-memory controller between the LSU and the local RAM / peripheral bus.
// One transaction at a time; loads return right-aligned, zero-extended data.
module nf_dm_ctrl #(
    parameter int          RAM_AW      = 12,
    parameter logic [31:0] RAM_MASK    = 32'hFFFF_0000,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter int          PER_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_dm,
    input  logic [31:0]       wd_dm,
    input  logic              we_dm,
    input  logic [1:0]        size_dm,
    input  logic              req_dm,
    output logic [31:0]       rd_dm,
    output logic              req_ack_dm,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wd,
    output logic [3:0]        ram_be,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [31:0]       ram_rd,
    output logic [31:0]       per_addr,
    output logic [31:0]       per_wd,
    output logic [3:0]        per_be,
    output logic              per_we,
    output logic              per_req,
    input  logic              per_ack,
    input  logic [31:0]       per_rd,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int             CW       = $clog2(PER_TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_CYC = CW'(PER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM,
        S_RAM_WAIT,
        S_PER,
        S_ACK
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wd;
    logic [3:0]    r_be;
    logic [1:0]    r_size;
    logic          r_we;
    logic          r_mis;
    logic          r_bus;
    logic [31:0]   r_rd;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic          w_mis;
    logic          w_hit;
    logic          w_per_last;

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] off,
                                             input logic [1:0] sz);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (sz)
            2'd0:    fmt_load = {24'h0, s[7:0]};
            2'd1:    fmt_load = {16'h0, s[15:0]};
            default: fmt_load = s;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        w_be = 4'h0;
        w_wd = wd_dm;
        case (size_dm)
            2'd0: begin
                w_be = 4'b0001 << addr_dm[1:0];
                w_wd = {4{wd_dm[7:0]}};
            end
            2'd1: begin
                w_be = 4'b0011 << {addr_dm[1], 1'b0};
                w_wd = {2{wd_dm[15:0]}};
            end
            2'd2:    w_be = 4'hF;
            default: w_be = 4'h0;
        endcase
    end

    assign w_mis = (size_dm == 2'd3) ||
                   (size_dm == 2'd1 && addr_dm[0]) ||
                   (size_dm == 2'd2 && addr_dm[1:0] != 2'b00);
    assign w_hit      = (addr_dm & RAM_MASK) == RAM_BASE;
    assign w_per_last = (r_cnt == LAST_CYC);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_dm) begin
                    if (w_mis)      w_next = S_ACK;
                    else if (w_hit) w_next = S_RAM;
                    else            w_next = S_PER;
                end
            end
            S_RAM:      w_next = r_we ? S_ACK : S_RAM_WAIT;
            S_RAM_WAIT: w_next = S_ACK;
            S_PER:      if (per_ack || w_per_last) w_next = S_ACK;
            S_ACK:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_wd   <= '0;
            r_be   <= '0;
            r_size <= '0;
            r_we   <= 1'b0;
            r_mis  <= 1'b0;
            r_bus  <= 1'b0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (req_dm) begin
                        r_addr <= addr_dm;
                        r_wd   <= w_wd;
                        r_be   <= w_be;
                        r_size <= size_dm;
                        r_we   <= we_dm;
                        r_mis  <= w_mis;
                        if (w_mis) r_rd <= '0;
                    end
                end
                S_RAM_WAIT: r_rd <= fmt_load(ram_rd, r_addr[1:0], r_size);
                S_PER: begin
                    // Ack in the last allowed cycle still wins over the timeout.
                    if (per_ack) begin
                        if (!r_we) r_rd <= fmt_load(per_rd, r_addr[1:0], r_size);
                    end else if (w_per_last) begin
                        r_rd  <= '0;
                        r_bus <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    r_mis <= 1'b0;
                    r_bus <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rd_dm        = r_rd;
    assign req_ack_dm   = (r_state == S_ACK);
    assign misalign_err = req_ack_dm && r_mis;
    assign bus_err      = req_ack_dm && r_bus;

    assign ram_addr = r_addr[RAM_AW+1:2];
    assign ram_wd   = r_wd;
    assign ram_be   = r_be;
    assign ram_en   = (r_state == S_RAM);
    assign ram_we   = ram_en && r_we;

    assign per_addr = r_addr;
    assign per_wd   = r_wd;
    assign per_be   = r_be;
    assign per_req  = (r_state == S_PER);
    assign per_we   = per_req && r_we;

endmodule

// File: tb/tb_nf_dm_ctrl.sv
// Directed self-checking bench for nf_dm_ctrl: RAM, byte lanes, misalign,
// peripheral ack/timeout and reset abort, with a small RAM and peripheral model.
module tb_nf_dm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_dm = '0;
    logic [31:0] wd_dm = '0;
    logic        we_dm = 1'b0;
    logic [1:0]  size_dm = '0;
    logic        req_dm = 1'b0;
    logic [31:0] rd_dm;
    logic        req_ack_dm;
    logic [11:0] ram_addr;
    logic [31:0] ram_wd;
    logic [3:0]  ram_be;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_rd;
    logic [31:0] per_addr;
    logic [31:0] per_wd;
    logic [3:0]  per_be;
    logic        per_we;
    logic        per_req;
    logic        per_ack = 1'b0;
    logic [31:0] per_rd = '0;
    logic        misalign_err;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    nf_dm_ctrl dut (
        .clk(clk), .rst(rst),
        .addr_dm(addr_dm), .wd_dm(wd_dm), .we_dm(we_dm), .size_dm(size_dm),
        .req_dm(req_dm), .rd_dm(rd_dm), .req_ack_dm(req_ack_dm),
        .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_be(ram_be),
        .ram_en(ram_en), .ram_we(ram_we), .ram_rd(ram_rd),
        .per_addr(per_addr), .per_wd(per_wd), .per_be(per_be),
        .per_we(per_we), .per_req(per_req), .per_ack(per_ack), .per_rd(per_rd),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // RAM model: 16 words, read data valid the cycle after ram_en.
    logic [31:0] mem [0:15];
    logic [31:0] mem_q = '0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_wd[8*b +: 8];
            mem_q <= mem[ram_addr[3:0]];
        end
    end
    assign ram_rd = ovr_en ? ovr_val : mem_q;

    // Peripheral model: ack during PER cycle per_ack_at (0 = never).
    int          per_ack_at = 0;
    logic [31:0] per_rd_val = '0;
    int          per_k = 0;
    always @(negedge clk) begin
        if (per_req) per_k = per_k + 1;
        else         per_k = 0;
        per_ack = per_req && (per_k == per_ack_at);
        per_rd  = per_ack ? per_rd_val : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Values captured while a transaction runs.
    int          lat, n_ram, n_per;
    logic [31:0] c_rd, c_ram_wd, c_per_addr, c_per_wd;
    logic [11:0] c_ram_addr;
    logic [3:0]  c_ram_be, c_per_be;
    logic        c_ram_we, c_per_we, c_mis, c_bus;

    // Called in an IDLE cycle just after a rising edge; returns one cycle after ACK.
    task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [1:0] sz);
        addr_dm = a; wd_dm = wd; we_dm = we; size_dm = sz; req_dm = 1'b1;
        lat = 0; n_ram = 0; n_per = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ram_en) begin
                n_ram++;
                c_ram_addr = ram_addr; c_ram_be = ram_be; c_ram_wd = ram_wd; c_ram_we = ram_we;
            end
            if (per_req) begin
                n_per++;
                c_per_addr = per_addr; c_per_be = per_be; c_per_wd = per_wd; c_per_we = per_we;
            end
            if (req_ack_dm) begin
                lat = i; c_rd = rd_dm; c_mis = misalign_err; c_bus = bus_err;
                req_dm = 1'b0;
                break;
            end
        end
        req_dm = 1'b0;
        if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", rd_dm, 32'h0);
        check("rst_ctl", {req_ack_dm, ram_en, ram_we, per_req, per_we, misalign_err, bus_err}, 32'h0);
        check("rst_ram", {ram_addr, ram_be, ram_wd[15:0]}, 32'h0);
        check("rst_per", per_addr | per_wd | {28'h0, per_be}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. RAM word store then load
        run(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 2'd2);
        check("st_w_lat", lat, 2);
        check("st_w_addr", c_ram_addr, 32'd4);
        check("st_w_be", c_ram_be, 32'hF);
        check("st_w_wd", c_ram_wd, 32'hDEAD_BEEF);
        check("st_w_we", {n_ram[7:0], 7'h0, c_ram_we}, 32'h0101);
        run(32'h0000_0010, 32'h0, 1'b0, 2'd2);
        check("ld_w_lat", lat, 3);
        check("ld_w_rd", c_rd, 32'hDEAD_BEEF);
        check("ld_w_we", c_ram_we, 32'h0);
        check("rd_hold", rd_dm, 32'hDEAD_BEEF);

        // 2. Byte lanes
        run(32'h0000_0013, 32'h1234_56A5, 1'b1, 2'd0);
        check("st_b_be", c_ram_be, 32'b1000);
        check("st_b_wd", c_ram_wd, 32'hA5A5_A5A5);
        run(32'h0000_0016, 32'h1111_CAFE, 1'b1, 2'd1);
        check("st_h_be", c_ram_be, 32'b1100);
        check("st_h_wd", c_ram_wd, 32'hCAFE_CAFE);
        ovr_en = 1'b1; ovr_val = 32'h1234_5678;
        run(32'h0000_0012, 32'h0, 1'b0, 2'd1);
        ovr_en = 1'b0;
        check("ld_h_ovr", c_rd, 32'h0000_1234);
        run(32'h0000_0012, 32'h0, 1'b0, 2'd1);
        check("ld_h_mem", c_rd, 32'h0000_A5AD);
        run(32'h0000_0011, 32'h0, 1'b0, 2'd0);
        check("ld_b_mem", c_rd, 32'h0000_00BE);

        // 3. Misaligned
        run(32'h0000_0006, 32'h0, 1'b0, 2'd2);
        check("mis_w_lat", lat, 1);
        check("mis_w_flags", {c_mis, c_bus}, 32'b10);
        check("mis_w_rd", c_rd, 32'h0);
        check("mis_w_nobus", n_ram + n_per, 0);
        check("mis_clr", {misalign_err, req_ack_dm}, 32'h0);
        run(32'h0000_0000, 32'h0, 1'b0, 2'd3);
        check("mis_s3", {lat[7:0], 7'h0, c_mis, n_ram[7:0], n_per[7:0]}, 32'h01_01_00_00);
        run(32'h0000_0001, 32'h0, 1'b1, 2'd1);
        check("mis_h", {lat[7:0], 7'h0, c_mis, n_ram[7:0], n_per[7:0]}, 32'h01_01_00_00);

        // 4. Peripheral load, ack on PER cycle 3
        per_ack_at = 3; per_rd_val = 32'hCAFE_0001;
        run(32'h8000_0004, 32'h0, 1'b0, 2'd2);
        check("per_lat", lat, 4);
        check("per_cycles", n_per, 3);
        check("per_be", c_per_be, 32'hF);
        check("per_addr", c_per_addr, 32'h8000_0004);
        check("per_rd", c_rd, 32'hCAFE_0001);
        check("per_bus", {c_bus, c_mis, c_per_we}, 32'h0);
        per_ack_at = 1;
        run(32'h8000_0003, 32'h0, 1'b0, 2'd0);
        check("per_b_lat", lat, 2);
        check("per_b_be", c_per_be, 32'b1000);
        check("per_b_rd", c_rd, 32'h0000_00CA);

        // 6. Reset mid-PER aborts; then a RAM load runs normally
        per_ack_at = 0;
        addr_dm = 32'h8000_0008; we_dm = 1'b0; size_dm = 2'd2; req_dm = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_pre", {per_req, rd_dm[7:0]}, {1'b1, 8'hCA});
        req_dm = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ctl", {per_req, req_ack_dm, bus_err}, 32'h0);
        check("abort_rd", rd_dm, 32'h0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", {per_req, req_ack_dm}, 32'h0);
        run(32'h0000_0010, 32'h0, 1'b0, 2'd2);
        check("post_rst_lat", lat, 3);
        check("post_rst_rd", c_rd, 32'hA5AD_BEEF);

        // 5. Peripheral timeout, then ack on the final cycle
        per_ack_at = 0;
        run(32'h8000_0000, 32'h0102_0304, 1'b1, 2'd2);
        check("to_cycles", n_per, 16);
        check("to_lat", lat, 17);
        check("to_bus", c_bus, 32'h1);
        check("to_rd", c_rd, 32'h0);
        check("to_wd", {c_per_wd[30:0], c_per_we}, {31'h0102_0304, 1'b1});
        check("to_clr", bus_err, 32'h0);
        per_ack_at = 16;
        run(32'h8000_0000, 32'h0102_0304, 1'b1, 2'd2);
        check("last_cycles", n_per, 16);
        check("last_bus", {lat[7:0], 7'h0, c_bus}, {8'd17, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
